// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline sequencing bundle: hazard/handshake inputs and per-register
// advance/hold/bubble controls, plus observability outputs.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRd;
    logic [4:0]       IF_ID_RegisterRs1;
    logic [4:0]       IF_ID_RegisterRs2;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_Flush;
    logic             ID_Flush_lwstall;
    logic             ID_EX_Write;
    logic             EX_MEM_Write;
    logic             MEM_WB_Flush;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;
    logic [1:0]       state_dbg;

    // Pipeline side: drives hazard/handshake info, consumes controls.
    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRs1, IF_ID_RegisterRs2,
               branch_taken, mem_req, mem_ack,
        input  PC_Write, IF_ID_Write, IF_Flush, ID_Flush_lwstall, ID_EX_Write,
               EX_MEM_Write, MEM_WB_Flush, stall_count, mem_timeout, state_dbg
    );

    // Controller side.
    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRs1, IF_ID_RegisterRs2,
               branch_taken, mem_req, mem_ack,
        output PC_Write, IF_ID_Write, IF_Flush, ID_Flush_lwstall, ID_EX_Write,
               EX_MEM_Write, MEM_WB_Flush, stall_count, mem_timeout, state_dbg
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use bubbles,
// taken-branch IF/ID flush and data-memory wait freezes, with a saturating
// stall-cycle counter and a sticky memory-timeout flag.
module hazard_stall_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input logic              clk,
    input logic              reset,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLwBubble = 2'd1,
        StMemWait  = 2'd2,
        StUnused   = 2'd3
    } state_e;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic memstall;
    logic lu_hazard;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_flush, id_flush, mem_wb_flush;

    assign memstall  = bus.mem_req & ~bus.mem_ack;
    assign lu_hazard = bus.ID_EX_MemRead && (bus.ID_EX_RegisterRd != 5'd0) &&
                       ((bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRs1) ||
                        (bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRs2));

    // Next-state, wait counter and pipeline controls; priority memstall > load-use > branch.
    always_comb begin
        state_d      = StRun;
        wait_d       = 8'd0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        mem_wb_flush = 1'b0;
        unique case (state_q)
            StRun, StMemWait, StLwBubble: begin
                if (memstall) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_flush = 1'b1;
                    state_d      = StMemWait;
                    // Continuing waits count up (saturating); a fresh wait starts at 1.
                    if (state_q == StMemWait) begin
                        wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
                    end else begin
                        wait_d = 8'd1;
                    end
                end else if (lu_hazard && (state_q != StLwBubble)) begin
                    // ID is held and re-evaluated, so a coincident branch is not flushed yet.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_flush    = 1'b1;
                    state_d     = StLwBubble;
                end else begin
                    if_flush = bus.branch_taken;
                end
            end
            default: ; // unused encoding: plain advance, recover to StRun
        endcase
        // Held reset presents the idle advance pattern regardless of inputs.
        if (!reset) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_flush     = 1'b0;
            id_flush     = 1'b0;
            mem_wb_flush = 1'b0;
        end
    end

    // Sticky timeout and saturating stall counter next values.
    always_comb begin
        timeout_d   = timeout_q | (wait_d == MaxWait);
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            wait_q      <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PC_Write         = pc_write;
    assign bus.IF_ID_Write      = if_id_write;
    assign bus.ID_EX_Write      = id_ex_write;
    assign bus.EX_MEM_Write     = ex_mem_write;
    assign bus.IF_Flush         = if_flush;
    assign bus.ID_Flush_lwstall = id_flush;
    assign bus.MEM_WB_Flush     = mem_wb_flush;
    assign bus.stall_count      = stall_cnt_q;
    assign bus.mem_timeout      = timeout_q;
    assign bus.state_dbg        = state_q;
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Decides each cycle whether the PC, IF/ID, ID/EX and EX/MEM registers advance, hold, or take a bubble.
- Handles three cases: load-use hazards (drives the ID/EX control-clear input), taken-branch flush of IF/ID, and multi-cycle data-memory waits via a req/ack handshake.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
- MAX_WAIT, 15: MEM_WAIT cycle count at which mem_timeout is set (1..255).
- CNT_W, 32: width of stall_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ID_EX_MemRead  in  1  MemRead of the instruction now in EX.
- ID_EX_RegisterRd  in  5  destination register of the instruction in EX.
- IF_ID_RegisterRs1  in  5  rs1 of the instruction in ID.
- IF_ID_RegisterRs2  in  5  rs2 of the instruction in ID.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- mem_req  in  1  EX/MEM instruction accesses data memory (MemRead or MemWrite).
- mem_ack  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_Flush  out  1  clear IF/ID on the next edge.
- ID_Flush_lwstall  out  1  clear ID/EX control fields on the next edge.
- ID_EX_Write  out  1  ID/EX load enable.
- EX_MEM_Write  out  1  EX/MEM load enable.
- MEM_WB_Flush  out  1  load a bubble into MEM/WB.
- stall_count  out  CNT_W  saturating count of cycles with PC_Write=0.
- mem_timeout  out  1  sticky: a memory wait reached MAX_WAIT.
- state_dbg  out  2  current FSM state encoding.

Behaviour:
- FSM states: RUN=0, LW_BUBBLE=1, MEM_WAIT=2. Encoding 3 is unused and recovers to RUN on the next edge.
- Outputs are combinational from state and inputs. stall_count, mem_timeout and the wait counter are registered.
- Reset (reset=0, async):
  - state=RUN, stall_count=0, mem_timeout=0, wait counter=0.
  - While reset is held, outputs take their RUN/no-hazard values: all *_Write=1, all flushes=0.
  - Reset asserted mid-wait or mid-bubble aborts to RUN immediately; no pending stall survives.
- Definitions:
  - memstall = mem_req & ~mem_ack.
  - lu_hazard = ID_EX_MemRead & (ID_EX_RegisterRd != 0) & (Rd == Rs1 | Rd == Rs2).
- Priority within a cycle: memstall > lu_hazard > branch_taken.
- RUN:
  - memstall: all four *_Write=0, MEM_WB_Flush=1, other flushes=0. Next state MEM_WAIT; wait counter loads 1.
  - else lu_hazard: PC_Write=0, IF_ID_Write=0, ID_Flush_lwstall=1, ID_EX_Write=1, EX_MEM_Write=1. IF_Flush=0 even if branch_taken, because ID is held and re-evaluates. Next state LW_BUBBLE.
  - else branch_taken: all Writes=1, IF_Flush=1. Stay in RUN.
  - else: all Writes=1, no flush.
- LW_BUBBLE (exactly one cycle):
  - Hazard detection is suppressed.
  - memstall: behave as in RUN memstall and go to MEM_WAIT.
  - else: normal advance; branch_taken gives IF_Flush=1. Next state RUN.
- MEM_WAIT:
  - While mem_ack=0: full freeze (all Writes=0, MEM_WB_Flush=1); wait counter increments, saturating at 255.
  - When the counter equals MAX_WAIT: mem_timeout<=1 and stays set until reset. Waiting continues.
  - Cycle with mem_ack=1: outputs as in RUN with memstall=0. lu_hazard and branch are evaluated normally; a lu_hazard goes to LW_BUBBLE, otherwise the next state is RUN. Wait counter clears.
  - mem_req deasserting without ack is treated as ack (defensive).
- stall_count increments on every edge where PC_Write=0 and saturates at all-ones; it does not wrap.
- Rd=x0 never triggers a load-use stall.

Test Plan:
- lw x5 in EX (ID_EX_MemRead=1, Rd=5), ID Rs1=5 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_Flush_lwstall=1; next cycle all Writes=1; stall_count=1.
- Same as above but Rd=0, Rs1=0 -> no stall; stall_count stays 0.
- Load-use and branch_taken in the same cycle -> IF_Flush=0 in the stall cycle; IF_Flush=1 in the following cycle if branch_taken is still 1.
- mem_req=1, mem_ack=0 for 3 cycles, then ack -> 3 frozen cycles with MEM_WB_Flush=1, release on the ack cycle, stall_count=3, mem_timeout=0.
- MAX_WAIT=4, mem_ack withheld 6 cycles -> mem_timeout rises after the 4th wait cycle, stays 1 after ack, clears only when reset=0.
- Assert reset=0 asynchronously in the middle of MEM_WAIT -> state_dbg=0 and all Writes=1 without waiting for a clock edge; stall_count=0.
